trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer_pkg.sv | 34 +++
 rtl/trap_sequencer.sv | 138 +++++++++++++
 tb/tb_trap_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_sequencer_pkg
//  Description : Shared encodings for the trap sequencer and the fetch-stage
//                PC mux that consumes its redirect select.
//                  - FSM state codes (IDLE, COMMIT, REDIRECT, DRAIN)
//                  - Do_pc_sel codes (SEL_SEQ, SEL_MTVEC, SEL_MEPC)
//                  - latched trap kind codes
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_sequencer_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COMMIT   = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    // PC mux select codes; 2'b11 is reserved and never driven
    localparam logic [1:0] SEL_SEQ   = 2'b00;
    localparam logic [1:0] SEL_MTVEC = 2'b01;
    localparam logic [1:0] SEL_MEPC  = 2'b10;

    // Latched trap kind; ECALL is the reset value
    localparam logic KIND_ECALL = 1'b0;
    localparam logic KIND_MRET  = 1'b1;

    // Redirect select for a given trap kind
    function automatic logic [1:0] redirect_sel(input logic kind);
        return (kind == KIND_MRET) ? SEL_MEPC : SEL_MTVEC;
    endfunction

endpackage : trap_sequencer_pkg
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : trap_sequencer
//  Description : Sequences ECALL / MRET traps out of the execute stage:
//                COMMIT pulse to the exception handler, one REDIRECT cycle
//                steering fetch to mtvec/mepc, then FLUSH_CYCLES cycles of
//                DRAIN while younger instructions are squashed.
//  Ports       : clk, reset_x (async, active-low)
//                Di_valid, Di_ecall_dec, Di_mret_dec, Di_PC  - execute stage
//                Di_mepc, Di_mtvec                           - CSR values
//                Do_ecall, Do_mret, Do_PC                    - commit to handler
//                Do_pc_sel, Do_next_PC                       - fetch redirect
//                Do_stall, Do_flush, Do_busy, Do_trap_cnt    - pipeline control
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2      // DRAIN cycles, legal 1..15
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        Di_valid,
    input  logic        Di_ecall_dec,
    input  logic        Di_mret_dec,
    input  logic [31:0] Di_PC,
    input  logic [31:0] Di_mepc,
    input  logic [31:0] Di_mtvec,
    output logic        Do_ecall,
    output logic        Do_mret,
    output logic [31:0] Do_PC,
    output logic [1:0]  Do_pc_sel,
    output logic [31:0] Do_next_PC,
    output logic        Do_stall,
    output logic        Do_flush,
    output logic        Do_busy,
    output logic [7:0]  Do_trap_cnt
);

    localparam logic [3:0] C_FLUSH = 4'(FLUSH_CYCLES);

    logic [1:0]  state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic        kind_q,      kind_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    logic [7:0]  trap_cnt_q,  trap_cnt_d;

    logic        w_event;

    assign w_event = Di_valid & (Di_ecall_dec | Di_mret_dec);

    // ------------------------------------------------------------------
    // Next-state logic. Inputs are only looked at in IDLE, so anything
    // arriving while a trap is in flight (including the last DRAIN cycle)
    // is dropped rather than queued.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kind_d      = kind_q;
        drain_cnt_d = drain_cnt_q;
        trap_cnt_d  = trap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_event) begin
                    pc_d    = Di_PC;
                    // ECALL has priority when both decode flags are set
                    kind_d  = Di_ecall_dec ? KIND_ECALL : KIND_MRET;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (kind_q == KIND_ECALL) begin
                    trap_cnt_d = trap_cnt_q + 8'd1;     // wraps 255 -> 0
                end
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                drain_cnt_d = C_FLUSH;
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leaving on count 1 gives exactly FLUSH_CYCLES DRAIN cycles;
                // <= also recovers from an out-of-range count of 0.
                if (drain_cnt_q <= 4'd1) begin
                    drain_cnt_d = 4'd0;
                    state_d     = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q     <= ST_IDLE;
            pc_q        <= 32'd0;
            kind_q      <= KIND_ECALL;
            drain_cnt_q <= 4'd0;
            trap_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kind_q      <= kind_d;
            drain_cnt_q <= drain_cnt_d;
            trap_cnt_q  <= trap_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the registered state so that reset clears them
    // asynchronously along with the flops.
    // ------------------------------------------------------------------
    always_comb begin
        Do_busy    = (state_q != ST_IDLE);
        Do_stall   = Do_busy;
        Do_flush   = (state_q == ST_REDIRECT) || (state_q == ST_DRAIN);
        Do_ecall   = (state_q == ST_COMMIT) && (kind_q == KIND_ECALL);
        Do_mret    = (state_q == ST_COMMIT) && (kind_q == KIND_MRET);
        Do_PC      = pc_q;
        Do_pc_sel  = (state_q == ST_REDIRECT) ? redirect_sel(kind_q) : SEL_SEQ;
        Do_trap_cnt = trap_cnt_q;

        // Targets pass straight through; mepc+4 is the handler's job
        case (Do_pc_sel)
            SEL_MTVEC: Do_next_PC = Di_mtvec;
            SEL_MEPC:  Do_next_PC = Di_mepc;
            default:   Do_next_PC = 32'd0;
        endcase
    end

endmodule : trap_sequencer
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_sequencer
//  Description : Directed self-checking bench for trap_sequencer
//                (FLUSH_CYCLES = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_sequencer;

    logic        clk;
    logic        reset_x;
    logic        Di_valid;
    logic        Di_ecall_dec;
    logic        Di_mret_dec;
    logic [31:0] Di_PC;
    logic [31:0] Di_mepc;
    logic [31:0] Di_mtvec;
    logic        Do_ecall;
    logic        Do_mret;
    logic [31:0] Do_PC;
    logic [1:0]  Do_pc_sel;
    logic [31:0] Do_next_PC;
    logic        Do_stall;
    logic        Do_flush;
    logic        Do_busy;
    logic [7:0]  Do_trap_cnt;

    int n_checks = 0;
    int n_errors = 0;

    trap_sequencer #(.FLUSH_CYCLES(2)) u_dut (
        .clk         (clk),
        .reset_x     (reset_x),
        .Di_valid    (Di_valid),
        .Di_ecall_dec(Di_ecall_dec),
        .Di_mret_dec (Di_mret_dec),
        .Di_PC       (Di_PC),
        .Di_mepc     (Di_mepc),
        .Di_mtvec    (Di_mtvec),
        .Do_ecall    (Do_ecall),
        .Do_mret     (Do_mret),
        .Do_PC       (Do_PC),
        .Do_pc_sel   (Do_pc_sel),
        .Do_next_PC  (Do_next_PC),
        .Do_stall    (Do_stall),
        .Do_flush    (Do_flush),
        .Do_busy     (Do_busy),
        .Do_trap_cnt (Do_trap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic e, input logic m, input logic [31:0] pc);
        Di_valid     = v;
        Di_ecall_dec = e;
        Di_mret_dec  = m;
        Di_PC        = pc;
    endtask

    // All control outputs packed into one word: {busy,stall,flush,ecall,mret,pc_sel}
    function automatic logic [31:0] ctl();
        return {25'd0, Do_busy, Do_stall, Do_flush, Do_ecall, Do_mret, Do_pc_sel};
    endfunction

    initial begin
        int n_commits;
        logic seen_pulse;

        reset_x = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        Di_mepc  = 32'h0000_0104;
        Di_mtvec = 32'h0000_0800;

        // ---------------- reset state ----------------
        repeat (2) step();
        check("rst_ctl",     ctl(),       32'h0);
        check("rst_pc",      Do_PC,       32'h0);
        check("rst_next_pc", Do_next_PC,  32'h0);
        check("rst_cnt",     {24'd0, Do_trap_cnt}, 32'h0);
        @(negedge clk);
        reset_x = 1'b1;
        step();

        // ---------------- ECALL at 0x100 ----------------
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0100);
        step();                                   // T+1 COMMIT
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0DEAD);
        check("ecall_commit_ctl", ctl(), 32'b110_10_00);
        check("ecall_commit_pc",  Do_PC, 32'h100);
        step();                                   // T+2 REDIRECT
        check("ecall_redir_ctl",  ctl(), 32'b111_00_01);
        check("ecall_redir_npc",  Do_next_PC, 32'h800);
        check("ecall_cnt",        {24'd0, Do_trap_cnt}, 32'd1);
        step();                                   // T+3 DRAIN
        check("ecall_drain1_ctl", ctl(), 32'b111_00_00);
        check("ecall_drain1_npc", Do_next_PC, 32'h0);
        step();                                   // T+4 DRAIN
        check("ecall_drain2_ctl", ctl(), 32'b111_00_00);
        step();                                   // T+5 IDLE
        check("ecall_idle_ctl",   ctl(), 32'h0);

        // ---------------- MRET ----------------
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0300);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("mret_commit_ctl", ctl(), 32'b110_01_00);
        check("mret_commit_pc",  Do_PC, 32'h300);
        step();
        check("mret_redir_ctl",  ctl(), 32'b111_00_10);
        check("mret_redir_npc",  Do_next_PC, 32'h104);
        check("mret_cnt",        {24'd0, Do_trap_cnt}, 32'd1);
        repeat (3) step();
        check("mret_idle_ctl",   ctl(), 32'h0);

        // ---------------- both flags: ECALL wins ----------------
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("both_commit_ctl", ctl(), 32'b110_10_00);
        step();
        check("both_redir_ctl",  ctl(), 32'b111_00_01);
        check("both_cnt",        {24'd0, Do_trap_cnt}, 32'd2);
        repeat (3) step();

        // ---------------- flags without valid ----------------
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0500);
        step();
        check("novalid_ctl1", ctl(), 32'h0);
        step();
        check("novalid_ctl2", ctl(), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // ---------------- event held through DRAIN ----------------
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0100);
        step();                                   // COMMIT
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0200);   // keep requesting
        check("hold_commit_pc", Do_PC, 32'h100);
        step();                                   // REDIRECT
        step();                                   // DRAIN
        check("hold_drain1_ctl", ctl(), 32'b111_00_00);
        step();                                   // DRAIN (return cycle)
        check("hold_drain2_ctl", ctl(), 32'b111_00_00);
        step();                                   // first IDLE
        check("hold_idle_ctl",   ctl(), 32'h0);
        step();                                   // accepted from IDLE
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check("hold_commit2_ctl", ctl(), 32'b110_10_00);
        check("hold_commit2_pc",  Do_PC, 32'h200);
        step();                                   // REDIRECT
        check("hold_cnt", {24'd0, Do_trap_cnt}, 32'd4);

        // ---------------- reset during REDIRECT ----------------
        repeat (3) step();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0600);
        step();                                   // COMMIT
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();                                   // REDIRECT
        check("abort_pre_ctl", ctl(), 32'b111_00_10);
        reset_x = 1'b0;
        #1;
        check("abort_ctl",    ctl(),      32'h0);
        check("abort_pc",     Do_PC,      32'h0);
        check("abort_npc",    Do_next_PC, 32'h0);
        check("abort_cnt",    {24'd0, Do_trap_cnt}, 32'h0);
        #1;
        reset_x = 1'b1;
        seen_pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Do_ecall || Do_mret || Do_busy || (Do_pc_sel != 2'b00)) seen_pulse = 1'b1;
        end
        check("abort_no_activity", {31'd0, seen_pulse}, 32'd0);

        // ---------------- 256 back-to-back ECALLs ----------------
        n_commits = 0;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0700);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            step();
            if (Do_ecall) begin
                n_commits++;
                if (n_commits >= 255) begin
                    if (n_commits == 256) drive(1'b0, 1'b0, 1'b0, 32'h0);
                    step();                       // REDIRECT: count updated
                    if (n_commits == 255) begin
                        check("wrap_cnt_255", {24'd0, Do_trap_cnt}, 32'd255);
                    end else begin
                        check("wrap_cnt_0", {24'd0, Do_trap_cnt}, 32'd0);
                        break;
                    end
                end
            end
        end
        check("wrap_commits", n_commits, 32'd256);
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_trap_sequencer
`default_nettype wire
